// File: rtl/serial_rx_controller.sv
// Serial frame receiver: 2-flop synchroniser, start/data/stop sequencing with mid-bit
// sampling, and a one-deep valid/ready output buffer with error and overrun pulses.
module serial_rx_controller #(
  parameter int BIT_TICKS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serialIn,
  output logic [DATA_WIDTH-1:0] parallelOut,
  output logic                  frameValid,
  input  logic                  frameReady,
  output logic                  frameError,
  output logic                  overrun,
  output logic                  busy,
  output logic [1:0]            stateDbg
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(BIT_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t state, stateNext;
  logic sync1, s;
  logic [CNT_W-1:0] counter, counterNext;
  logic [IDX_W-1:0] bitIdx, bitIdxNext;
  logic [DATA_WIDTH-1:0] shift, shiftNext;
  logic errNext, goodStop, loadOk;

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    bitIdxNext  = bitIdx;
    shiftNext   = shift;
    errNext     = 1'b0;
    goodStop    = 1'b0;
    case (state)
      IDLE: begin
        counterNext = '0;
        if (s) stateNext = START;
      end
      START: begin
        if (counter == HALF_TC) begin
          counterNext = '0;
          if (s) begin
            bitIdxNext = '0;
            stateNext  = DATA;
          end else begin
            errNext   = 1'b1;
            stateNext = IDLE;
          end
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end
      DATA: begin
        if (counter == FULL_TC) begin
          counterNext = '0;
          shiftNext   = {s, shift[DATA_WIDTH-1:1]};
          bitIdxNext  = bitIdx + IDX_W'(1);
          if (bitIdx == LAST_IDX) stateNext = STOP;
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end
      STOP: begin
        if (counter == FULL_TC) begin
          counterNext = '0;
          stateNext   = IDLE;
          if (!s) goodStop = 1'b1;
          else    errNext  = 1'b1;
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // frameValid/frameReady: a byte transfers on any cycle where both are high; frameValid
  // holds until then, and frameReady is ignored while frameValid is low.
  assign loadOk = goodStop && (!frameValid || frameReady);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b0;
      s           <= 1'b0;
      state       <= IDLE;
      counter     <= '0;
      bitIdx      <= '0;
      shift       <= '0;
      parallelOut <= '0;
      frameValid  <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync1      <= serialIn;
      s          <= sync1;
      state      <= stateNext;
      counter    <= counterNext;
      bitIdx     <= bitIdxNext;
      shift      <= shiftNext;
      frameError <= errNext;
      overrun    <= goodStop && !loadOk;
      if (loadOk) begin
        parallelOut <= shift;
        frameValid  <= 1'b1;
      end else if (frameValid && frameReady) begin
        frameValid <= 1'b0;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign stateDbg = state;

endmodule

// File: tb/tb_serial_rx_controller.sv
// Bench for serial_rx_controller: directed line waveforms, a frame-level reference model
// of the expected outputs, per-cycle comparison and pinned literal expectations.
module tb_serial_rx_controller;

  localparam int B    = 4;
  localparam int DW   = 8;
  localparam int HALF = B / 2;
  localparam int N    = 400;

  logic clock = 1'b0;
  logic reset, serialIn, frameReady;
  logic [DW-1:0] parallelOut;
  logic frameValid, frameError, overrun, busy;
  logic [1:0] stateDbg;

  int checks = 0;
  int failures = 0;

  bit line [N];
  bit ready [N];
  bit rst [N];
  bit loadAt [N];
  logic [DW-1:0] loadData [N];
  bit expValid [N], expErr [N], expOvr [N], expBusy [N];
  logic [DW-1:0] expData [N];
  logic actValid [N], actErr [N], actOvr [N], actBusy [N];
  logic [DW-1:0] actData [N];

  serial_rx_controller #(.BIT_TICKS(B), .DATA_WIDTH(DW), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .serialIn(serialIn),
    .parallelOut(parallelOut), .frameValid(frameValid), .frameReady(frameReady),
    .frameError(frameError), .overrun(overrun), .busy(busy), .stateDbg(stateDbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // A frame whose raw start edge is at cycle r occupies cycles r .. r+(DW+2)*B-1.
  task automatic putFrame(input int r, input logic [DW-1:0] d, input bit stopBit);
    for (int k = 0; k < B; k++) begin
      line[r+k] = 1'b1;
      line[r+(DW+1)*B+k] = stopBit;
      for (int i = 0; i < DW; i++) line[r+(i+1)*B+k] = d[i];
    end
  endtask

  // Synchronised line as seen in cycle c: raw value two cycles back, zero after a reset.
  function automatic bit sAt(input int c);
    if (c < 2 || c - 2 >= N) return 1'b0;
    if (rst[c-1] || rst[c-2]) return 1'b0;
    return line[c-2];
  endfunction

  task automatic buildModel();
    int c, t0, tEnd, abortAt;
    bit ok, v;
    logic [DW-1:0] d, q;
    c = 1;
    d = '0;
    while (c < N) begin
      if (!sAt(c)) begin
        c++;
        continue;
      end
      t0 = c;
      tEnd = t0 + HALF;
      ok = sAt(tEnd);
      if (ok) begin
        for (int i = 0; i < DW; i++) d[i] = sAt(t0 + HALF + (i + 1) * B);
        tEnd = t0 + HALF + (DW + 1) * B;
      end
      abortAt = -1;
      for (int k = t0; k <= tEnd && k < N; k++)
        if (rst[k] && abortAt < 0) abortAt = k;
      if (abortAt >= 0) begin
        for (int k = t0 + 1; k <= abortAt; k++) expBusy[k] = 1'b1;
        c = abortAt + 1;
      end else begin
        for (int k = t0 + 1; k <= tEnd && k < N; k++) expBusy[k] = 1'b1;
        if (tEnd + 1 < N) begin
          if (!ok || sAt(tEnd)) expErr[tEnd+1] = 1'b1;
          else begin
            loadAt[tEnd] = 1'b1;
            loadData[tEnd] = d;
          end
        end
        c = tEnd + 1;
      end
    end
    v = 1'b0;
    q = '0;
    for (int k = 1; k < N; k++) begin
      expValid[k] = v;
      expData[k] = q;
      if (rst[k]) begin
        v = 1'b0;
        q = '0;
      end else if (loadAt[k]) begin
        if (!v || ready[k]) begin
          v = 1'b1;
          q = loadData[k];
        end else if (k + 1 < N) begin
          expOvr[k+1] = 1'b1;
        end
      end else if (v && ready[k]) begin
        v = 1'b0;
      end
    end
  endtask

  task automatic driveCycle(input int k);
    reset = rst[k];
    serialIn = line[k];
    frameReady = ready[k];
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      line[k] = 1'b0; ready[k] = 1'b0; rst[k] = 1'b0; loadAt[k] = 1'b0;
      loadData[k] = '0; expValid[k] = 1'b0; expErr[k] = 1'b0; expOvr[k] = 1'b0;
      expBusy[k] = 1'b0; expData[k] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      line[k] = (k % 2 == 0);
    end
    putFrame(10, 8'hA5, 1'b0);
    for (int k = 10; k < 60; k++) ready[k] = 1'b1;
    line[60] = 1'b1;
    putFrame(70, 8'h3C, 1'b1);
    putFrame(120, 8'h11, 1'b0);
    putFrame(160, 8'h22, 1'b0);
    ready[210] = 1'b1;
    putFrame(220, 8'h55, 1'b0);
    putFrame(262, 8'h66, 1'b0);
    ready[302] = 1'b1;
    putFrame(310, 8'h77, 1'b0);
    for (int k = 330; k < 350; k++) line[k] = 1'b0;
    rst[330] = 1'b1;
    buildModel();

    driveCycle(0);
    fork
      begin
        for (int k = 1; k < N; k++) begin
          @(posedge clock);
          #1;
          driveCycle(k);
        end
      end
      begin
        for (int k = 1; k < N; k++) begin
          @(negedge clock);
          actValid[k] = frameValid;
          actErr[k] = frameError;
          actOvr[k] = overrun;
          actBusy[k] = busy;
          actData[k] = parallelOut;
          chk("frameValid", k, 32'(frameValid), 32'(expValid[k]));
          chk("parallelOut", k, 32'(parallelOut), 32'(expData[k]));
          chk("frameError", k, 32'(frameError), 32'(expErr[k]));
          chk("overrun", k, 32'(overrun), 32'(expOvr[k]));
          chk("busy", k, 32'(busy), 32'(expBusy[k]));
        end
      end
    join

    chk("lit_rst_busy", 2, 32'(actBusy[2]), 32'd0);
    chk("lit_rst_valid", 2, 32'(actValid[2]), 32'd0);
    chk("lit_rst_data", 3, 32'(actData[3]), 32'h00);
    chk("lit_a5_busy_lo", 12, 32'(actBusy[12]), 32'd0);
    chk("lit_a5_busy_hi", 13, 32'(actBusy[13]), 32'd1);
    chk("lit_a5_pre", 50, 32'(actValid[50]), 32'd0);
    chk("lit_a5_valid", 51, 32'(actValid[51]), 32'd1);
    chk("lit_a5_data", 51, 32'(actData[51]), 32'hA5);
    chk("lit_a5_busy_fall", 51, 32'(actBusy[51]), 32'd0);
    chk("lit_a5_post", 52, 32'(actValid[52]), 32'd0);
    chk("lit_glitch_err", 65, 32'(actErr[65]), 32'd1);
    chk("lit_glitch_err_pre", 64, 32'(actErr[64]), 32'd0);
    chk("lit_badstop_err", 111, 32'(actErr[111]), 32'd1);
    chk("lit_badstop_valid", 111, 32'(actValid[111]), 32'd0);
    chk("lit_badstop_data", 111, 32'(actData[111]), 32'hA5);
    chk("lit_ovr_pulse", 201, 32'(actOvr[201]), 32'd1);
    chk("lit_ovr_pre", 200, 32'(actOvr[200]), 32'd0);
    chk("lit_ovr_post", 202, 32'(actOvr[202]), 32'd0);
    chk("lit_ovr_data", 205, 32'(actData[205]), 32'h11);
    chk("lit_ovr_held", 210, 32'(actValid[210]), 32'd1);
    chk("lit_ovr_drain", 211, 32'(actValid[211]), 32'd0);
    chk("lit_sim_data", 303, 32'(actData[303]), 32'h66);
    chk("lit_sim_valid", 303, 32'(actValid[303]), 32'd1);
    chk("lit_sim_novr", 303, 32'(actOvr[303]), 32'd0);
    chk("lit_midrst_busy", 330, 32'(actBusy[330]), 32'd1);
    chk("lit_midrst_idle", 331, 32'(actBusy[331]), 32'd0);
    chk("lit_midrst_valid", N - 1, 32'(actValid[N-1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
